// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a one-byte holding register and valid/ack handshake.
// Reports framing errors, overrun and break, and shows BUSY while a frame is in flight.
module uart_rx_byte #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    input  logic       RD_ACK,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       FRAME_ERR,
    output logic       OVERRUN,
    output logic       BREAK_DET,
    output logic       BUSY
);

    localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic [15:0]            timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [7:0]             shift_q, shift_d;
    logic                   stop_wait_q, stop_wait_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   break_q, break_d;
    logic                   byte_done;
    logic                   ack;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            stop_wait_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            stop_wait_q <= stop_wait_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_wait_d = stop_wait_q;
        frame_err_d = 1'b0;
        break_d     = 1'b0;
        byte_done   = 1'b0;

        unique case (state_q)
            StIdle: begin
                timer_d   = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_q == HalfLast) begin
                    timer_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StData: begin
                if (timer_q == BitLast) begin
                    timer_d   = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StStop: begin
                if (stop_wait_q) begin
                    // Hold off after a bad stop until the line is released (break).
                    if (rx_s) begin
                        stop_wait_d = 1'b0;
                        state_d     = StIdle;
                    end
                end else if (timer_q == BitLast) begin
                    timer_d = '0;
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_d   = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        break_d     = (shift_q == 8'h00);
                        stop_wait_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ack = RD_ACK && valid_q;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // A completing byte wins over a same-cycle ack.
        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !RD_ACK) begin
                overrun_d = 1'b1;
            end
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign OVERRUN    = overrun_q;
    assign FRAME_ERR  = frame_err_q;
    assign BREAK_DET  = break_q;
    assign BUSY       = (state_q != StIdle);

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Receives the 8N1 asynchronous serial stream on the RX / MAGA_PC_RD lines and delivers bytes to the command/MAGA forwarding logic inside Top.
- Sits directly upstream of the byte consumer that drives DATA_OUT.
- Data is held in a one-byte register with a valid/acknowledge handshake.
- Flags framing errors, overrun and break conditions.

Parameters:
- CLKS_PER_BIT, 5208, CLK cycles per bit (50 MHz / 9600 baud); legal range 16..65535.
- SYNC_STAGES, 2, synchronizer flops on RX; legal range 2..3.

Ports:
- CLK  input  1  system clock, 50 MHz.
- RESET  input  1  synchronous, active-high reset.
- RX  input  1  asynchronous serial input; idles high.
- RD_ACK  input  1  consumer has taken DATA_OUT; single-cycle pulse or level.
- DATA_OUT  output  8  last received byte, LSB first on the wire.
- DATA_VALID  output  1  DATA_OUT holds an unread byte.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  output  1  sticky: a byte completed while DATA_VALID=1; cleared by RD_ACK or RESET.
- BREAK_DET  output  1  one-cycle pulse: frame with data 0x00 and stop bit low.
- BUSY  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (RESET sampled high on a CLK edge):
  - DATA_OUT=8'h00; DATA_VALID=0; FRAME_ERR=0; OVERRUN=0; BREAK_DET=0; BUSY=0.
  - FSM goes to IDLE; counters clear; synchronizer flops load 1.
  - A reset mid-frame abandons the frame. No output pulses are generated.
- Synchronizer: RX passes through SYNC_STAGES flops giving rx_s. All decisions use rx_s.
- Counters:
  - bit timer, 16-bit, counts 0..CLKS_PER_BIT-1;
  - bit index, 3-bit, counts 0..7.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - BUSY=0.
  - rx_s=0 -> START; timer cleared.
- START:
  - At timer = CLKS_PER_BIT/2 - 1 (integer divide), sample rx_s.
  - If rx_s=1: false start (glitch); return to IDLE with no output.
  - If rx_s=0: timer cleared; go to DATA.
- DATA:
  - At timer = CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, LSB first).
  - Bit index increments; after the 8th sample go to STOP.
  - Timer wraps to 0 on every sample.
- STOP:
  - At timer = CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 (good frame):
    - DATA_OUT <= shift on the next edge; DATA_VALID <= 1.
    - If DATA_VALID was already 1 and no RD_ACK this cycle, OVERRUN <= 1. The new byte overwrites the old one.
  - rx_s=0 (bad frame):
    - FRAME_ERR pulses 1 cycle; the byte is discarded; DATA_VALID unchanged.
    - If shift=8'h00, BREAK_DET also pulses.
  - Either way, return to IDLE.
  - A bad frame returns to IDLE only once rx_s=1, so no retrigger occurs during a break.
- Handshake:
  - RD_ACK while DATA_VALID=1 clears DATA_VALID and OVERRUN on the next edge.
  - RD_ACK while DATA_VALID=0 is ignored.
  - Simultaneous RD_ACK and byte completion: the new byte wins. DATA_VALID stays 1; OVERRUN is not set.
- Latency: DATA_VALID rises 1 CLK after the stop-bit mid-sample. That is about 9.5*CLKS_PER_BIT + SYNC_STAGES + 1 cycles after the RX falling edge.
- The next start bit is accepted immediately in IDLE; back-to-back frames are supported.

Test Plan:
- Reset, then RX idle high for 1 bit -> all outputs 0, BUSY=0.
- Single byte: start 0; data bits 1,0,0,0,0,0,1,0 (LSB first); stop 1; each bit 5208 cycles. Expect:
  - DATA_OUT=8'h41 and DATA_VALID=1 at about 49,476 cycles after the falling edge;
  - FRAME_ERR=0; BUSY low afterwards.
- Glitch: RX low for 1000 cycles, then high -> no DATA_VALID; FSM back in IDLE; BUSY pulse only.
- Framing/break: send 0x00 with stop bit 0 -> FRAME_ERR and BREAK_DET each high exactly 1 cycle; DATA_VALID stays 0.
- Overrun: send 0x41 then 0x5A back-to-back with no RD_ACK -> DATA_OUT=8'h5A, OVERRUN=1. A later RD_ACK -> DATA_VALID=0, OVERRUN=0.
- Reset mid-frame: RESET for 1 cycle during bit 4 of 0x41, then a clean 0x3C -> only 0x3C reported, with one DATA_VALID rise.
